data_axi_bridge: RTL



---
 rtl/data_axi_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_axi_bridge.sv
// Purpose: bridges the core's SRAM-like data port onto AXI3 AR/R/AW/W/B channels, one transaction in flight.
// Latency: zero-wait slave gives data_data_ok two cycles after acceptance (three with BRIDGE_RESP_REG_EN defined).
// Backpressure: data_addr_ok only in IDLE; AXI valids hold with stable payload until their ready is seen.
//
// Optional feature macro: BRIDGE_RESP_REG_EN registers the response (adds a RESP state and one cycle).
// Ports:
//   clk, reset                            clock, async active-high reset
//   data_req/wr/size/addr/wstrb/wdata     core request (accepted when data_addr_ok)
//   data_addr_ok, data_data_ok, data_rdata  core handshake and response
//   araddr/arsize/arvalid/arready         AXI read address
//   rdata/rvalid/rready                   AXI read data
//   awaddr/awsize/awvalid/awready         AXI write address
//   wdata/wstrb/wvalid/wready             AXI write data
//   bvalid/bready                         AXI write response
module data_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
`ifdef BRIDGE_RESP_REG_EN
        , RESP
`endif
    } state_t;

`ifdef BRIDGE_RESP_REG_EN
    localparam state_t AFTER_RESP = RESP;
`else
    localparam state_t AFTER_RESP = IDLE;
`endif

    state_t      state, next_state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        aw_done, w_done;
    logic        resp_take;   // R or B handshake completes this cycle

    always_comb begin
        next_state   = state;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        resp_take    = 1'b0;
        case (state)
            IDLE: begin
                // Gate with reset so the core never sees an accept while the bridge is held.
                data_addr_ok = ~reset;
                if (data_req) begin
                    next_state = data_wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) next_state = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    resp_take  = 1'b1;
                    next_state = AFTER_RESP;
                end
            end
            WR_REQ: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                // Each channel is complete if it finished earlier or handshakes now;
                // covers both finishing in the same cycle.
                if ((aw_done || awready) && (w_done || wready)) next_state = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    resp_take  = 1'b1;
                    next_state = AFTER_RESP;
                end
            end
`ifdef BRIDGE_RESP_REG_EN
            RESP: next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && data_req) begin
                addr_q  <= data_addr;
                size_q  <= data_size;
                wstrb_q <= data_wstrb;
                wdata_q <= data_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

`ifdef BRIDGE_RESP_REG_EN
    logic [31:0] rdata_q;

    // Capture read data at the handshake; writes capture zero so RESP can forward blindly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (resp_take) begin
            rdata_q <= (state == RD_DATA) ? rdata : 32'd0;
        end
    end

    assign data_data_ok = (state == RESP);
    assign data_rdata   = (state == RESP) ? rdata_q : 32'd0;
`else
    assign data_data_ok = resp_take;
    assign data_rdata   = (state == RD_DATA && rvalid) ? rdata : 32'd0;
`endif

endmodule
